serial_add_sub: RTL and testbench
=================================

# serial_add_sub

Bit-serial adder/subtractor: accepts two WIDTH-bit operands and a mode bit, then computes a+b or a−b one bit per clock through a single full_adder cell and a carry/borrow flop. It is the subtract-capable, area-minimal sequential counterpart to the ripple-carry adder. It sits in the arithmetic library as a drop-in for datapaths that trade latency for area, behind a simple start/done handshake.

## Interface
- WIDTH, 4, operand/result width in bits (≥2)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only when not busy
- sub  in  1  0 = a+b, 1 = a−b; sampled with start
- a  in  WIDTH  operand A, sampled with start
- b  in  WIDTH  operand B, sampled with start
- busy  out  1  high while computing
- done  out  1  one-cycle pulse, result valid
- result  out  WIDTH  sum/difference, held until next accepted start
- cout  out  1  add: carry out; sub: 1 = no borrow (a ≥ b unsigned)
- ovf  out  1  two's-complement signed overflow

## Operation
- States: IDLE, RUN, DONE.
- IDLE/DONE + start=1: load shift regs A←a, B←(sub ? ~b : b); carry flop c←sub; bit counter←0; go RUN.
- start while RUN: ignored; operands and sub not re-sampled.
- RUN, each cycle: {co,s}=full_adder(A[0],B[0],c); shift s into result MSB (result shifts right); A,B shift right; c←co; counter++.
- On bit WIDTH−1: capture carry-in of that bit as c_msb; cout←co; ovf←c_msb ^ co; go DONE.
- DONE: done=1 for exactly one cycle; next state IDLE unless start=1 (then RUN, back-to-back).
- result, cout, ovf only update on completion of a RUN sequence; stable from done until the next completion.
- Arithmetic is modulo 2^WIDTH; subtraction is a + ~b + 1.
- Reset (any time, incl. mid-RUN): state IDLE, busy=0, done=0, result=0, cout=0, ovf=0, counter=0, c=0; in-flight operation discarded.

## Timing
- start sampled at edge k → busy=1 from k+1 through the edge k+WIDTH.
- done=1 in the cycle following edge k+WIDTH (latency WIDTH cycles start→done); busy=0 in that cycle.
- Throughput: one operation per WIDTH+1 cycles with start held high (start accepted in DONE cycle).
- No combinational path from inputs to outputs; all outputs registered.

## Structure
- Shared package/include: state encoding localparams (IDLE, RUN, DONE) and counter width function clog2(WIDTH).
- Sub-module: one instance of existing full_adder (a, b, cin, sum, cout) for the bit cell; everything else in serial_add_sub.

## Test plan
- WIDTH=4, add 3+5 → result=1000, cout=0, ovf=1; done exactly 4 cycles after start, busy high 4 cycles.
- Add 15+1 → result=0000, cout=1, ovf=0; sub 5−3 → result=0010, cout=1, ovf=0.
- Sub 3−5 → result=1110, cout=0, ovf=0; sub 8−1 (−8−1) → result=0111, cout=1, ovf=1.
- Exhaustive: all 512 {sub,a,b} vs behavioral model (result, cout, ovf), back-to-back with start held high; no idle gaps beyond one DONE cycle.
- Start pulsed with different operands during RUN → ignored; result matches first operands; done fires once.
- Assert rst_n low at bit 2 of an operation → outputs all 0 immediately, state IDLE; new start after release completes correctly with no stale carry.

Source files
------------

// File: rtl/serial_add_sub_pkg.sv
// rtl/serial_add_sub_pkg.sv - shared state encoding and sizing helper for serial_add_sub
package serial_add_sub_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit full adder cell
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_sub.sv
// rtl/serial_add_sub.sv - bit-serial adder/subtractor, one bit per clock, start/done handshake
module serial_add_sub
  import serial_add_sub_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    cnt;
  logic             c;
  logic             s;
  logic             co;

  full_adder u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (c),
    .sum  (s),
    .cout (co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      acc    <= '0;
      cnt    <= '0;
      c      <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            // Subtraction is a + ~b + 1: invert b here, the +1 enters as the initial carry.
            a_sr  <= a;
            b_sr  <= sub ? ~b : b;
            c     <= sub;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          acc  <= {s, acc[WIDTH-1:1]};
          a_sr <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr <= {1'b0, b_sr[WIDTH-1:1]};
          c    <= co;
          cnt  <= cnt + CW'(1);
          if (cnt == LAST) begin
            // c is the carry into the sign bit; overflow when it differs from the carry out.
            result <= {s, acc[WIDTH-1:1]};
            cout   <= co;
            ovf    <= c ^ co;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_sub.sv
// tb/tb_serial_add_sub.sv - directed and exhaustive self-checking bench for serial_add_sub
module tb_serial_add_sub;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;

  int n_checks;
  int n_pass;

  serial_add_sub #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .sub    (sub),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .ovf    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for done after the accepting edge; returns cycles elapsed and busy-high samples.
  task automatic wait_done(output int cyc, output int busy_cnt);
    cyc = 0;
    busy_cnt = 0;
    while (!done && cyc < 20) begin
      if (busy) busy_cnt++;
      tick();
      cyc++;
    end
  endtask

  task automatic directed(input string tag, input logic s_in, input logic [W-1:0] a_in,
                          input logic [W-1:0] b_in, input logic [W-1:0] exp_res,
                          input logic exp_c, input logic exp_v);
    int cyc;
    int bc;
    start = 1'b1; sub = s_in; a = a_in; b = b_in;
    tick();
    start = 1'b0;
    wait_done(cyc, bc);
    check({tag, "_lat"}, cyc, W);
    check({tag, "_busy"}, bc, W);
    check({tag, "_res"}, result, exp_res);
    check({tag, "_cout"}, cout, exp_c);
    check({tag, "_ovf"}, ovf, exp_v);
    tick();
    check({tag, "_done_pulse"}, done, 0);
  endtask

  initial begin
    int cyc;
    int bc;
    int dcount;
    logic [8:0] op;
    logic [W-1:0] bb;
    logic [W:0] sum5;
    logic [W-1:0] mres;
    logic mv;

    n_checks = 0; n_pass = 0;
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_cout_ovf", {cout, ovf}, 0);
    rst_n = 1'b1;
    tick();

    directed("add_3_5",  1'b0, 4'd3,  4'd5, 4'b1000, 1'b0, 1'b1);
    directed("add_15_1", 1'b0, 4'd15, 4'd1, 4'b0000, 1'b1, 1'b0);
    directed("sub_5_3",  1'b1, 4'd5,  4'd3, 4'b0010, 1'b1, 1'b0);
    directed("sub_3_5",  1'b1, 4'd3,  4'd5, 4'b1110, 1'b0, 1'b0);
    directed("sub_8_1",  1'b1, 4'd8,  4'd1, 4'b0111, 1'b1, 1'b1);

    // Exhaustive back-to-back with start held high.
    op = '0;
    start = 1'b1; {sub, a, b} = op;
    tick();
    for (int i = 0; i < 512; i++) begin
      op = 9'(i);
      if (i < 511) {sub, a, b} = 9'(i + 1);
      else start = 1'b0;
      wait_done(cyc, bc);
      bb = op[8] ? ~op[3:0] : op[3:0];
      sum5 = {1'b0, op[7:4]} + {1'b0, bb} + {{W{1'b0}}, op[8]};
      mres = sum5[W-1:0];
      mv = (op[7] == bb[3]) && (mres[3] != op[7]);
      check("exh_lat", cyc, W);
      check("exh_res", {op, result}, {op, mres});
      check("exh_cout", {op, cout}, {op, sum5[W]});
      check("exh_ovf", {op, ovf}, {op, mv});
      if (i < 511) tick();
    end
    tick();
    check("exh_idle_busy", busy, 0);

    // Start pulsed with other operands during RUN must be ignored.
    start = 1'b1; sub = 1'b0; a = 4'd2; b = 4'd3;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1; sub = 1'b1; a = 4'd7; b = 4'd7;
    tick();
    start = 1'b0;
    cyc = 2;
    while (!done && cyc < 20) begin tick(); cyc++; end
    check("ign_lat", cyc, W);
    check("ign_res", result, 4'd5);
    check("ign_cout_ovf", {cout, ovf}, 2'b00);
    dcount = 0;
    for (int k = 0; k < 8; k++) begin tick(); if (done) dcount++; end
    check("ign_single_done", dcount, 0);
    check("ign_idle", busy, 0);

    // Reset mid-operation (during bit 2), then a fresh op must see no stale carry.
    start = 1'b1; sub = 1'b0; a = 4'd6; b = 4'd7;
    tick();
    start = 1'b0;
    tick(); tick();
    check("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_result", result, 0);
    check("mid_rst_cout_ovf", {cout, ovf}, 0);
    tick();
    check("mid_rst_hold", {busy, done, result}, 0);
    rst_n = 1'b1;
    tick();
    directed("post_rst_add_1_1", 1'b0, 4'd1, 4'd1, 4'd2, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
